// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - MEM-stage data-memory request/response bus
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [2:0]  req_size;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_size, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_size, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency little-endian data-memory responder
// One request in flight; storage is eight byte lanes so an aligned access stays in one row.
module data_mem_responder #(
   parameter int DEPTH_BYTES = 256,
   parameter int LATENCY     = 2
) (
   input logic                 clk,
   input logic                 reset,
   data_mem_responder_if.slave bus
);
   localparam int ROWS = DEPTH_BYTES / 8;
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW   = $clog2(LATENCY + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic          lat_write;
   logic [63:0]   lat_addr;
   logic [63:0]   lat_wdata;
   logic [2:0]    lat_size;
   logic          resp_valid_q;
   logic          resp_err_q;
   logic [63:0]   resp_rdata_q;

   logic [3:0]    nbytes;
   logic [2:0]    align_mask;
   logic [64:0]   end_addr;
   logic          access_err;
   logic          commit;
   logic          store_en;
   logic [2:0]    off;
   logic [RW-1:0] row;
   logic [7:0]    lane_en;
   logic [63:0]   wshift;
   logic [63:0]   word_rd;
   logic [63:0]   raw;
   logic [63:0]   ext;
   logic [63:0]   load_data;

   always_comb begin
      case (lat_size[1:0])
         2'd0:    nbytes = 4'd1;
         2'd1:    nbytes = 4'd2;
         2'd2:    nbytes = 4'd4;
         default: nbytes = 4'd8;
      endcase
   end

   // 65-bit end address so a request near 2^64 cannot wrap back into range
   assign align_mask = nbytes[2:0] - 3'd1;
   assign end_addr   = {1'b0, lat_addr} + {61'd0, nbytes};
   assign access_err = (lat_size == 3'b111)
                     || ((lat_addr[2:0] & align_mask) != 3'd0)
                     || (end_addr > 65'(DEPTH_BYTES));

   assign off      = lat_addr[2:0];
   assign row      = RW'(lat_addr[63:3]);
   assign commit   = (state == ST_BUSY) && (cnt == CW'(1));
   assign store_en = commit && lat_write && !access_err && !reset;
   assign wshift   = lat_wdata << {off, 3'b000};

   always_comb begin
      lane_en = 8'd0;
      for (int b = 0; b < 8; b++) begin
         lane_en[b] = (4'(b) >= {1'b0, off}) && (4'(b) < ({1'b0, off} + nbytes));
      end
   end

   for (genvar b = 0; b < 8; b++) begin : g_lane
      logic [7:0] bank [ROWS];

      always_ff @(posedge clk) begin
         if (store_en && lane_en[b]) begin
            bank[row] <= wshift[8*b +: 8];
         end
      end

      assign word_rd[8*b +: 8] = bank[row];
   end

   assign raw = word_rd >> {off, 3'b000};

   always_comb begin
      case (lat_size)
         3'b000:  ext = {{56{raw[7]}},  raw[7:0]};
         3'b001:  ext = {{48{raw[15]}}, raw[15:0]};
         3'b010:  ext = {{32{raw[31]}}, raw[31:0]};
         3'b011:  ext = raw;
         3'b100:  ext = {56'd0, raw[7:0]};
         3'b101:  ext = {48'd0, raw[15:0]};
         3'b110:  ext = {32'd0, raw[31:0]};
         default: ext = 64'd0;
      endcase
   end

   assign load_data = (lat_write || access_err) ? 64'd0 : ext;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         lat_write    <= 1'b0;
         lat_addr     <= 64'd0;
         lat_wdata    <= 64'd0;
         lat_size     <= 3'd0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 64'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  lat_write <= bus.req_write;
                  lat_addr  <= bus.req_addr;
                  lat_wdata <= bus.req_wdata;
                  lat_size  <= bus.req_size;
                  cnt       <= CW'(LATENCY);
                  state     <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               cnt <= cnt - CW'(1);
               if (commit) begin
                  resp_rdata_q <= load_data;
                  resp_err_q   <= access_err;
                  resp_valid_q <= 1'b1;
                  state        <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs forced to their reset values while reset is held, even before the first edge
   assign bus.req_ready  = (state == ST_IDLE) && !reset;
   assign bus.resp_valid = resp_valid_q && !reset;
   assign bus.resp_rdata = reset ? 64'd0 : resp_rdata_q;
   assign bus.resp_err   = resp_err_q && !reset;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed and randomized bench for data_mem_responder
module tb_data_mem_responder;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        rv [2];
   logic        rw [2];
   logic        rr [2];
   logic [63:0] ra [2];
   logic [63:0] rd [2];
   logic [2:0]  rs [2];

   data_mem_responder_if bus0();
   data_mem_responder_if bus1();

   assign bus0.req_valid  = rv[0];
   assign bus0.req_write  = rw[0];
   assign bus0.req_addr   = ra[0];
   assign bus0.req_wdata  = rd[0];
   assign bus0.req_size   = rs[0];
   assign bus0.resp_ready = rr[0];
   assign bus1.req_valid  = rv[1];
   assign bus1.req_write  = rw[1];
   assign bus1.req_addr   = ra[1];
   assign bus1.req_wdata  = rd[1];
   assign bus1.req_size   = rs[1];
   assign bus1.resp_ready = rr[1];

   data_mem_responder #(.DEPTH_BYTES(256), .LATENCY(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   data_mem_responder #(.DEPTH_BYTES(256), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   int compared = 0;
   int mismatched = 0;
   int lat [2] = '{2, 1};

   logic [7:0]  mdl [2][256];
   logic [63:0] exp_r [2];
   logic        exp_e [2];
   bit          pend_wr [2];
   logic [63:0] pend_a [2];
   logic [63:0] pend_d [2];
   int          pend_n [2];
   logic [63:0] last_r [2];

   function automatic logic q_ready(int w);
      return (w == 0) ? bus0.req_ready : bus1.req_ready;
   endfunction
   function automatic logic q_valid(int w);
      return (w == 0) ? bus0.resp_valid : bus1.resp_valid;
   endfunction
   function automatic logic [63:0] q_rdata(int w);
      return (w == 0) ? bus0.resp_rdata : bus1.resp_rdata;
   endfunction
   function automatic logic q_err(int w);
      return (w == 0) ? bus0.resp_err : bus1.resp_err;
   endfunction

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: byte-array model evaluated at request time, store applied when acknowledged
   task automatic issue(int w, bit wr, logic [63:0] a, logic [63:0] d, logic [2:0] s);
      int n;
      int bits;
      logic [63:0] v;
      n = 1 << s[1:0];
      exp_e[w] = (s == 3'b111) || ((a % 64'(n)) != 64'd0) || (a > 64'(256 - n));
      v = 64'd0;
      if (!exp_e[w] && !wr) begin
         for (int k = 0; k < n; k++) v = v | (64'(mdl[w][int'(a[7:0]) + k]) << (8 * k));
         bits = 8 * n;
         if (!s[2] && n < 8 && v[bits-1]) v = v | ~((64'd1 << bits) - 64'd1);
      end
      exp_r[w]   = v;
      pend_wr[w] = wr && !exp_e[w];
      pend_a[w]  = a;
      pend_d[w]  = d;
      pend_n[w]  = n;
      rv[w] = 1'b1;
      rw[w] = wr;
      ra[w] = a;
      rd[w] = d;
      rs[w] = s;
   endtask

   task automatic accept(int w, string tag);
      int cyc = 0;
      while (!q_ready(w) && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_ready"}, 64'(q_ready(w)), 64'd1);
      @(posedge clk); #1;
      rv[w] = 1'b0;
      ra[w] = {$urandom, $urandom};
      rd[w] = {$urandom, $urandom};
      rs[w] = 3'($urandom_range(0, 7));
      rw[w] = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_resp(int w, string tag);
      int cyc = 0;
      while (!q_valid(w) && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_lat"}, 64'(cyc), 64'(lat[w]));
   endtask

   task automatic collect(int w, int hold, string tag);
      logic [63:0] snap;
      snap = q_rdata(w);
      for (int i = 0; i < hold; i++) begin
         chk({tag, "_hold_valid"}, 64'(q_valid(w)), 64'd1);
         chk({tag, "_hold_rdata"}, q_rdata(w), snap);
         chk({tag, "_hold_ready"}, 64'(q_ready(w)), 64'd0);
         @(posedge clk); #1;
      end
      chk({tag, "_rdata"}, q_rdata(w), exp_r[w]);
      chk({tag, "_err"}, 64'(q_err(w)), 64'(exp_e[w]));
      last_r[w] = q_rdata(w);
      rr[w] = 1'b1;
      @(posedge clk); #1;
      rr[w] = 1'b0;
      chk({tag, "_valid_drop"}, 64'(q_valid(w)), 64'd0);
      chk({tag, "_ready_back"}, 64'(q_ready(w)), 64'd1);
      if (pend_wr[w]) begin
         for (int k = 0; k < pend_n[w]; k++) mdl[w][int'(pend_a[w][7:0]) + k] = pend_d[w][8*k +: 8];
      end
      pend_wr[w] = 1'b0;
   endtask

   task automatic xact(int w, bit wr, logic [63:0] a, logic [63:0] d, logic [2:0] s, int hold, string tag);
      issue(w, wr, a, d, s);
      accept(w, tag);
      wait_resp(w, tag);
      collect(w, hold, tag);
   endtask

   task automatic chk_reset_outputs(int w, string tag);
      chk({tag, "_req_ready"}, 64'(q_ready(w)), 64'd0);
      chk({tag, "_resp_valid"}, 64'(q_valid(w)), 64'd0);
      chk({tag, "_resp_rdata"}, q_rdata(w), 64'd0);
      chk({tag, "_resp_err"}, 64'(q_err(w)), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] e_r;
      logic        e_e;
      logic [63:0] snap;
      logic [63:0] a;
      logic [2:0]  s;
      int          n;

      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 256; i++) mdl[w][i] = 8'd0;
         rv[w] = 1'b0; rw[w] = 1'b0; rr[w] = 1'b0;
         ra[w] = 64'd0; rd[w] = 64'd0; rs[w] = 3'd0;
         pend_wr[w] = 1'b0;
      end

      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs(0, "rst0");
      chk_reset_outputs(1, "rst1");
      reset = 1'b0;
      #1;
      chk("rst0_ready_after", 64'(q_ready(0)), 64'd1);
      chk("rst1_ready_after", 64'(q_ready(1)), 64'd1);

      xact(0, 1'b1, 64'h10, 64'h8877665544332211, 3'b011, 0, "sd10");
      xact(0, 1'b0, 64'h10, 64'd0, 3'b011, 0, "ld10");
      chk("ld10_const", last_r[0], 64'h8877665544332211);

      xact(0, 1'b0, 64'h17, 64'd0, 3'b000, 0, "lb17");
      chk("lb17_const", last_r[0], 64'hFFFFFFFFFFFFFF88);
      xact(0, 1'b0, 64'h17, 64'd0, 3'b100, 1, "lbu17");
      chk("lbu17_const", last_r[0], 64'h88);
      xact(0, 1'b0, 64'h16, 64'd0, 3'b001, 0, "lh16");
      chk("lh16_const", last_r[0], 64'hFFFFFFFFFFFF8877);
      xact(0, 1'b0, 64'h14, 64'd0, 3'b110, 0, "lwu14");
      chk("lwu14_const", last_r[0], 64'h88776655);

      xact(0, 1'b1, 64'h21, 64'hBEEF, 3'b001, 0, "sh21");
      chk("sh21_err_const", 64'(exp_e[0]), 64'd1);
      xact(0, 1'b0, 64'h20, 64'd0, 3'b011, 0, "ld20");
      chk("ld20_const", last_r[0], 64'd0);
      xact(0, 1'b0, 64'hF8, 64'd0, 3'b011, 0, "ldF8");
      xact(0, 1'b0, 64'h100, 64'd0, 3'b011, 0, "ld100");
      xact(0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 3'b011, 0, "ldwrap");
      xact(0, 1'b0, 64'h18, 64'd0, 3'b111, 0, "size7");

      issue(0, 1'b0, 64'h10, 64'd0, 3'b011);
      accept(0, "t4a");
      wait_resp(0, "t4a");
      e_r = exp_r[0];
      e_e = exp_e[0];
      snap = q_rdata(0);
      issue(0, 1'b0, 64'h14, 64'd0, 3'b010);
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold_valid", 64'(q_valid(0)), 64'd1);
         chk("t4_hold_rdata", q_rdata(0), snap);
         chk("t4_hold_ready", 64'(q_ready(0)), 64'd0);
         @(posedge clk); #1;
      end
      chk("t4a_rdata", q_rdata(0), e_r);
      chk("t4a_err", 64'(q_err(0)), 64'(e_e));
      rr[0] = 1'b1;
      @(posedge clk); #1;
      rr[0] = 1'b0;
      chk("t4_valid_drop", 64'(q_valid(0)), 64'd0);
      chk("t4_ready_next", 64'(q_ready(0)), 64'd1);
      accept(0, "t4b");
      wait_resp(0, "t4b");
      collect(0, 0, "t4b");
      chk("t4b_const", last_r[0], 64'hFFFFFFFF88776655);

      issue(0, 1'b1, 64'h30, 64'h1234, 3'b011);
      accept(0, "t5");
      reset = 1'b1;
      #1;
      chk_reset_outputs(0, "t5_rst_a");
      @(posedge clk); #1;
      chk_reset_outputs(0, "t5_rst_b");
      @(posedge clk); #1;
      reset = 1'b0;
      pend_wr[0] = 1'b0;
      pend_wr[1] = 1'b0;
      #1;
      chk("t5_ready_after", 64'(q_ready(0)), 64'd1);
      chk("t5_valid_after", 64'(q_valid(0)), 64'd0);
      xact(0, 1'b0, 64'h30, 64'd0, 3'b011, 0, "t5_ld30");
      chk("t5_ld30_const", last_r[0], 64'd0);

      for (int i = 0; i < 8; i++) begin
         xact(1, 1'b1, 64'h40 + 64'(i), 64'(i + 1), 3'b000, 0, "t6_sb");
      end
      xact(1, 1'b0, 64'h40, 64'd0, 3'b011, 0, "t6_ld40");
      chk("t6_ld40_const", last_r[1], 64'h0807060504030201);

      for (int t = 0; t < 60; t++) begin
         int w;
         w = (t % 3 == 2) ? 1 : 0;
         s = 3'($urandom_range(0, 7));
         n = 1 << s[1:0];
         a = 64'($urandom_range(32'h80, 32'h107));
         if ($urandom_range(0, 4) != 0) a = a & ~64'(n - 1);
         if ($urandom_range(0, 9) == 0) a = {$urandom, $urandom};
         xact(w, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, s, $urandom_range(0, 2), "rnd");
      end

      for (int k = 16'h80; k < 16'h100; k += 8) begin
         xact(0, 1'b0, 64'(k), 64'd0, 3'b011, 0, "rnd_dump0");
         xact(1, 1'b0, 64'(k), 64'd0, 3'b011, 0, "rnd_dump1");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
